// File: rtl/arb_defs.sv
// Shared definitions for the round-robin bus arbiter: FSM encoding,
// requester count and default widths.
package arb_defs;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int NREQ   = 4;
  localparam int DEF_W  = 16;
  localparam int DEF_CW = 8;

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Bus interface of rr_bus_arbiter. Handshake: a word on o is transferred in
// every cycle where valid and ready are both high; optional lock (ARB_LOCK_EN).
interface rr_bus_arbiter_if #(
  parameter int W  = arb_defs::DEF_W,
  parameter int CW = arb_defs::DEF_CW
);
  logic [3:0]      req;
  logic [W-1:0]    i0;
  logic [W-1:0]    i1;
  logic [W-1:0]    i2;
  logic [W-1:0]    i3;
  logic            ready;
  logic [3:0]      gnt;
  logic [1:0]      s;
  logic [W-1:0]    o;
  logic            valid;
  logic [3:0]      ack;
  logic [CW-1:0]   cnt;
  arb_defs::state_t state;
`ifdef ARB_LOCK_EN
  logic [3:0]      lock;

  modport master (input req, i0, i1, i2, i3, ready, lock,
                  output gnt, s, o, valid, ack, cnt, state);
  modport slave  (output req, i0, i1, i2, i3, ready, lock,
                  input gnt, s, o, valid, ack, cnt, state);
`else
  modport master (input req, i0, i1, i2, i3, ready,
                  output gnt, s, o, valid, ack, cnt, state);
  modport slave  (output req, i0, i1, i2, i3, ready,
                  input gnt, s, o, valid, ack, cnt, state);
`endif
endinterface

// File: rtl/bus_mux4.sv
// 4:1 bus multiplexer, select is the binary requester index.
module bus_mux4 #(
  parameter int W = 16
) (
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic [W-1:0] i2,
  input  logic [W-1:0] i3,
  input  logic [1:0]   s,
  output logic [W-1:0] o
);
  always_comb begin
    case (s)
      2'd0:    o = i0;
      2'd1:    o = i1;
      2'd2:    o = i2;
      default: o = i3;
    endcase
  end
endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first asserted (req & ~mask) bit scanning
// from ptr upward, modulo 4.
module rr_pick4
  import arb_defs::*;
(
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx,
  output logic [3:0] onehot
);
  logic [3:0] eff;
  logic [1:0] cand;

  always_comb begin
    eff   = req & ~mask;
    found = 1'b0;
    idx   = 2'd0;
    cand  = 2'd0;
    // Scan from the far end so the candidate closest to ptr is written last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (eff[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    onehot = found ? (4'b0001 << idx) : 4'b0000;
  end
endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4:1 bus with valid/ready output
// handshake and transfer counter. ARB_LOCK_EN adds burst ownership via lock.
module rr_bus_arbiter
  import arb_defs::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = DEF_CW
) (
  input logic            clk,
  input logic            rst,
  rr_bus_arbiter_if.master bus
);
  state_t        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    s_q, s_d;
  logic [1:0]    ptr_q, ptr_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          xfer;
  logic          owner_req;
  logic          hold_lock;
  logic [3:0]    pick_mask;
  logic [1:0]    pick_ptr;
  logic          pick_found;
  logic [1:0]    pick_idx;
  logic [3:0]    pick_onehot;

  assign xfer      = valid_q & bus.ready;
  assign owner_req = bus.req[s_q];
`ifdef ARB_LOCK_EN
  assign hold_lock = bus.lock[s_q];
`else
  assign hold_lock = 1'b0;
`endif

  // While busy the next owner is chosen past the current one, excluding it.
  assign pick_mask = (state_q == BUSY) ? gnt_q : 4'b0000;
  assign pick_ptr  = (state_q == BUSY) ? s_q + 2'd1 : ptr_q;

  rr_pick4 u_pick (
    .req    (bus.req),
    .mask   (pick_mask),
    .ptr    (pick_ptr),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          gnt_d   = pick_onehot;
          s_d     = pick_idx;
          valid_d = 1'b1;
        end
      end
      BUSY: begin
        if (xfer) begin
          cnt_d = cnt_q + CW'(1);
          if (!hold_lock) begin
            ptr_d = s_q + 2'd1;
            if (pick_found) begin
              gnt_d = pick_onehot;
              s_d   = pick_idx;
            end else begin
              state_d = IDLE;
              gnt_d   = 4'b0000;
              valid_d = 1'b0;
            end
          end
        end else if (!owner_req) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      s_q     <= 2'd0;
      ptr_q   <= 2'd0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  bus_mux4 #(.W(W)) u_mux (
    .i0 (bus.i0),
    .i1 (bus.i1),
    .i2 (bus.i2),
    .i3 (bus.i3),
    .s  (s_q),
    .o  (bus.o)
  );

  assign bus.gnt   = gnt_q;
  assign bus.s     = s_q;
  assign bus.valid = valid_q;
  assign bus.cnt   = cnt_q;
  assign bus.ack   = gnt_q & {4{bus.ready}};
  assign bus.state = state_q;
endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the 16-bit 4:1 bus multiplexer.
- Shares one output bus between four requesters (i0..i3).
- Drives the mux select from a registered grant and runs a valid/ready handshake with a single sink.
- Counts completed transfers.

Parameters:
- W, 16, data width of each requester input and of the bus output.
- CW, 8, width of the completed-transfer counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req  input  4  request per requester; req[k] belongs to ik.
- i0  input  W  requester 0 data.
- i1  input  W  requester 1 data.
- i2  input  W  requester 2 data.
- i3  input  W  requester 3 data.
- ready  input  1  sink accepts the bus word this cycle.
- gnt  output  4  registered one-hot grant; all zero when idle.
- s  output  2  registered mux select, binary index of the granted requester.
- o  output  W  bus word; equals i[s] combinationally through the 4:1 mux.
- valid  output  1  registered; high in state BUSY.
- ack  output  4  combinational: gnt & {4{ready}}; a one-cycle transfer strobe to the owner.
- cnt  output  CW  completed-transfer count; wraps modulo 2^CW.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer) sets these values:
  - state=IDLE, gnt=0, s=0, valid=0, cnt=0.
  - Round-robin pointer ptr=0, meaning requester 0 has highest priority.
  - An in-flight word is dropped; no ack.
- Pick function: first asserted req[k] scanning k = ptr, ptr+1, ... mod 4.
- State IDLE:
  - If req != 0, the next edge loads gnt/s with the pick and sets valid=1; go to BUSY.
  - Latency is one cycle from req to valid.
  - If req == 0, stay in IDLE.
- State BUSY, transfer (valid & ready):
  - ack[s]=1 that cycle; cnt increments; ptr becomes s+1 mod 4.
  - Pick among remaining requests with the owner's req masked, using the new ptr.
  - If a pick exists, grant it at the same edge: no idle bubble, valid stays 1.
  - Otherwise go to IDLE with gnt=0 and valid=0.
- State BUSY, no ready: gnt, s and o hold; the requester must hold its data stable.
- State BUSY, owner drops req before ready (abort):
  - Next edge goes to IDLE; ptr and cnt are unchanged; no ack.
  - An abort and a ready in the same cycle count as a transfer.
- Owner keeps req high after its ack: it competes again at lowest priority (fairness).
- Simultaneous requests are resolved by ptr only; a new request arriving while another owner is BUSY never preempts it.
- cnt wraps from 2^CW-1 to 0 silently.
- o is not masked when idle; consumers qualify it with valid.

Optional Feature:
- Macro: ARB_LOCK_EN.
- When defined, adds input lock [3:0]. If lock[s] is high at a transfer, the current owner keeps the grant: gnt, s, ptr and valid are unchanged. This gives burst ownership until lock drops, and the transfer on which lock is low releases the grant normally. lock from non-owners is ignored. cnt still counts every transfer.
- When undefined: no lock port; behaviour is exactly as above.

Decomposition:
- Shared package/header arb_defs:
  - State encodings IDLE=1'b0, BUSY=1'b1.
  - Requester count constant 4.
  - Default widths W=16, CW=8.
- Sub-module rr_pick4 (combinational):
  - Inputs: req[3:0], mask[3:0], ptr[1:0].
  - Outputs: found, idx[1:0], onehot[3:0].
- The top holds the FSM, registers and counter, and instantiates the existing 16-bit 4:1 mux for o.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> gnt=0, valid=0, cnt=0, s=0 throughout.
- req=4'b0100 with i2=16'hBEEF and ready=1 -> valid one cycle after req; o=16'hBEEF; ack=4'b0100; cnt=1; ptr=3.
- req=4'b1111 held, ready=1 continuously -> grant order 0,1,2,3,0 with no bubbles; cnt=5 after 5 transfers.
- Granted to 1, ready=0 for 3 cycles then 1 -> o stable at i1 for 4 cycles; a single ack[1] pulse; cnt+1.
- Owner 3 drops req while ready=0 -> IDLE next cycle, no ack, cnt unchanged; next req=4'b1001 grants 0 (ptr unchanged at 0).
- CW=2, 5 transfers -> cnt sequence 1,2,3,0,1. Assert rst mid-BUSY -> gnt=0, valid=0 immediately (asynchronous); with ARB_LOCK_EN, lock[0]=1 for 3 transfers keeps gnt=4'b0001 against req=4'b0011.
